// File: rtl/cd_tx_sched.sv
// cd_tx_sched: shares one CDBUS TX path between two byte-stream requesters.
// A round-robin grant picks one requester. Its frame is streamed into the
// cdbus TX RAM through tx_mm, then TX is started through csr. The flag
// register is then polled until the frame is reported sent or failed.
//
// Optional feature macro: CD_TX_SCHED_TIMEOUT_EN. It adds a poll watchdog
// with an abort command write.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   rN_valid/data/last      requester byte stream (N = 0,1)
//   rN_ready                byte accepted when valid && ready
//   rN_done / rN_err        one-cycle result pulses for the granted requester
//   tx_mm_*                 TX RAM write master (registered, one cycle after handshake)
//   csr_*                   CSR master; csr_readdata is valid the cycle after csr_read
module cd_tx_sched #(
  parameter logic [3:0]  ADDR_CMD   = 4'd9,
  parameter logic [31:0] START_MASK = 32'h0000_0002,
  parameter logic [3:0]  ADDR_FLAG  = 4'd10,
  parameter logic [31:0] DONE_MASK  = 32'h0000_0020,
  parameter logic [31:0] ERR_MASK   = 32'h0000_0080,
  parameter int          POLL_GAP   = 16
`ifdef CD_TX_SCHED_TIMEOUT_EN
  , parameter logic [19:0] TIMEOUT  = 20'hFFFFF
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r0_valid,
  input  logic [7:0]  r0_data,
  input  logic        r0_last,
  output logic        r0_ready,
  output logic        r0_done,
  output logic        r0_err,
  input  logic        r1_valid,
  input  logic [7:0]  r1_data,
  input  logic        r1_last,
  output logic        r1_ready,
  output logic        r1_done,
  output logic        r1_err,
  output logic [5:0]  tx_mm_address,
  output logic [3:0]  tx_mm_byteenable,
  output logic        tx_mm_write,
  output logic [31:0] tx_mm_writedata,
  output logic [3:0]  csr_address,
  output logic [3:0]  csr_byteenable,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_GAP, S_POLL, S_CHECK, S_DONE, S_ERR, S_ABORT
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_t      state, state_nx;
  logic        grant, last_grant;
  logic [1:0]  vld, rdy, done_q, err_q;
  logic [7:0]  cnt, gap_cnt, dat_sel;
  logic        last_sel, hs;
  logic        full;       // counter has wrapped: 256 bytes already written
  logic        ovf;        // a byte was discarded in this frame
  logic        flush;      // last byte taken; wait one cycle for its RAM write
  logic        flush_err;  // frame overflowed, skip START
  logic        timed_out;
  logic        rd_err, rd_done;
  logic        unused_rd;

  assign vld      = {r1_valid, r0_valid};
  assign rdy      = (state == S_LOAD && !flush) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign hs       = |(rdy & vld);
  assign dat_sel  = grant ? r1_data : r0_data;
  assign last_sel = grant ? r1_last : r0_last;
  assign rd_err   = |(csr_readdata & ERR_MASK);
  assign rd_done  = |(csr_readdata & DONE_MASK);
  assign unused_rd = ^csr_readdata;

  assign {r1_ready, r0_ready} = rdy;
  assign {r1_done, r0_done}   = done_q;
  assign {r1_err, r0_err}     = err_q;

`ifdef CD_TX_SCHED_TIMEOUT_EN
  logic [19:0] wdog;
  assign timed_out = (wdog >= TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog <= '0;
    else if (state == S_START) wdog <= '0;
    else if ((state == S_GAP || state == S_POLL || state == S_CHECK) && wdog != '1)
      wdog <= wdog + 20'd1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    csr_address    = '0;
    csr_byteenable = '0;
    csr_read       = 1'b0;
    csr_write      = 1'b0;
    csr_writedata  = '0;
    case (state)
      S_IDLE:  if (|vld) state_nx = S_LOAD;
      S_LOAD:  if (flush) state_nx = flush_err ? S_ERR : S_START;
      S_START: begin
        csr_address    = ADDR_CMD;
        csr_byteenable = 4'hF;
        csr_write      = 1'b1;
        csr_writedata  = START_MASK;
        state_nx       = S_GAP;
      end
      S_GAP: begin
        if (timed_out)              state_nx = S_ABORT;
        else if (gap_cnt == GAP_LAST) state_nx = S_POLL;
      end
      S_POLL: begin
        csr_address    = ADDR_FLAG;
        csr_byteenable = 4'hF;
        csr_read       = 1'b1;
        state_nx       = timed_out ? S_ABORT : S_CHECK;
      end
      // An observed result beats the watchdog; error beats done.
      S_CHECK: begin
        if (rd_err)         state_nx = S_ERR;
        else if (rd_done)   state_nx = S_DONE;
        else if (timed_out) state_nx = S_ABORT;
        else                state_nx = S_GAP;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      S_ABORT: begin
        csr_address    = ADDR_CMD;
        csr_byteenable = 4'hF;
        csr_write      = 1'b1;
        state_nx       = S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      cnt              <= '0;
      full             <= 1'b0;
      ovf              <= 1'b0;
      flush            <= 1'b0;
      flush_err        <= 1'b0;
      gap_cnt          <= '0;
      done_q           <= '0;
      err_q            <= '0;
      tx_mm_address    <= '0;
      tx_mm_byteenable <= '0;
      tx_mm_write      <= 1'b0;
      tx_mm_writedata  <= '0;
    end else begin
      tx_mm_write <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      gap_cnt     <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
      case (state)
        S_IDLE: begin
          cnt       <= '0;
          full      <= 1'b0;
          ovf       <= 1'b0;
          flush     <= 1'b0;
          flush_err <= 1'b0;
          // Tie goes to whoever was not served last; otherwise the lone requester.
          if (|vld) grant <= (&vld) ? ~last_grant : vld[1];
        end
        S_LOAD: if (hs) begin
          if (!full) begin
            tx_mm_write      <= 1'b1;
            tx_mm_address    <= cnt[7:2];
            tx_mm_byteenable <= 4'b0001 << cnt[1:0];
            tx_mm_writedata  <= {4{dat_sel}};
          end
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) full <= 1'b1;
          ovf <= ovf | full;
          if (last_sel) begin
            flush     <= 1'b1;
            flush_err <= ovf | full;
          end
        end
        S_DONE: begin
          done_q     <= grant ? 2'b10 : 2'b01;
          last_grant <= grant;
        end
        S_ERR: begin
          err_q      <= grant ? 2'b10 : 2'b01;
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_tx_sched.sv
module tb_cd_tx_sched;
  localparam int PG = 4;
  localparam logic [31:0] START = 32'h2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic r0_valid = 0, r0_last = 0, r1_valid = 0, r1_last = 0;
  logic [7:0] r0_data = 0, r1_data = 0;
  logic r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err;
  logic [5:0]  tx_mm_address;
  logic [3:0]  tx_mm_byteenable;
  logic        tx_mm_write;
  logic [31:0] tx_mm_writedata;
  logic [3:0]  csr_address, csr_byteenable;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata = '0;

  int tests = 0, fails = 0, cyc = 0;
  int n_wr = 0, n_csrw = 0, n_rd = 0, t_start = 0, t_ev = 0, t_hs = 0;
  int rd_cyc[$];
  int glog[$];
  logic [41:0] wq[$];
  logic [39:0] cwq[$];
  logic [3:0]  evq[$];
  logic [31:0] flag_q[$];
  logic [31:0] flag_dflt = 32'h20;
  logic [3:0]  ev;

  cd_tx_sched #(.POLL_GAP(PG)
`ifdef CD_TX_SCHED_TIMEOUT_EN
    , .TIMEOUT(20'd100)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last),
    .r0_ready(r0_ready), .r0_done(r0_done), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last),
    .r1_ready(r1_ready), .r1_done(r1_done), .r1_err(r1_err),
    .tx_mm_address(tx_mm_address), .tx_mm_byteenable(tx_mm_byteenable),
    .tx_mm_write(tx_mm_write), .tx_mm_writedata(tx_mm_writedata),
    .csr_address(csr_address), .csr_byteenable(csr_byteenable),
    .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flag register model: answers each read on the following cycle.
  always @(posedge clk) begin
    if (csr_read) csr_readdata <= (flag_q.size() != 0) ? flag_q.pop_front() : flag_dflt;
    else          csr_readdata <= '0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    chk("rdy_overlap", {127'd0, r0_ready & r1_ready}, 0);
    if (reset_n) begin
      if (tx_mm_write) begin
        n_wr++;
        chk("tx_wr", {tx_mm_address, tx_mm_byteenable, tx_mm_writedata},
            (wq.size() != 0) ? wq.pop_front() : '1);
      end
      if (csr_write) begin
        n_csrw++;
        if (csr_writedata == START) t_start = cyc;
        chk("csr_wr", {csr_address, csr_byteenable, csr_writedata},
            (cwq.size() != 0) ? cwq.pop_front() : '1);
      end
      if (csr_read) begin
        n_rd++;
        rd_cyc.push_back(cyc);
        chk("rd_addr", {csr_address, csr_byteenable}, {4'd10, 4'hF});
      end
      ev = {r1_err, r1_done, r0_err, r0_done};
      if (ev != 0) begin
        t_ev = cyc;
        chk("event", ev, (evq.size() != 0) ? evq.pop_front() : 4'hF);
      end
    end
  end

  function automatic logic rdy(input int r);
    return (r != 0) ? r1_ready : r0_ready;
  endfunction

  task automatic drive(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin r0_valid = v; r0_data = d; r0_last = l; end
    else        begin r1_valid = v; r1_data = d; r1_last = l; end
  endtask

  // Sends the first nsend bytes of a len-byte frame, one handshake per byte.
  task automatic send(input int r, input int len, input int base, input int nsend);
    logic [7:0] b;
    int t;
    for (int i = 0; i < nsend; i++) begin
      b = 8'(base + i);
      drive(r, 1'b1, b, i == len - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!rdy(r) && t < 2000);
      if (!rdy(r)) begin
        chk("ready_timeout", {127'd0, rdy(r)}, 1);
        break;
      end
      if (i == 0) glog.push_back(r);
      if (i == len - 1) t_hs = cyc;
      if (i < 256) wq.push_back({6'(i >> 2), 4'(1 << (i % 4)), {4{b}}});
      @(posedge clk); #1;
    end
    drive(r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string tag, input int budget);
    int t;
    t = 0;
    while ((evq.size() + cwq.size()) != 0 && t < budget) begin @(negedge clk); t++; end
    repeat (6) @(negedge clk);
    chk({"drain_", tag}, evq.size() + cwq.size() + wq.size(), 0);
  endtask

  int wr0, cw0, rd0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rn", {r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err}, 0);
    chk("rst_tx", {tx_mm_address, tx_mm_byteenable, tx_mm_write, tx_mm_writedata}, 0);
    chk("rst_csr", {csr_address, csr_byteenable, csr_read, csr_write, csr_writedata}, 0);
    reset_n = 1'b1;

    // Both requesters busy from reset: strict alternation starting with r0.
    for (int i = 0; i < 6; i++) begin
      cwq.push_back({4'd9, 4'hF, START});
      evq.push_back((i % 2 == 0) ? 4'b0001 : 4'b0100);
    end
    fork
      begin for (int k = 0; k < 3; k++) send(0, 2, 8'h20 + 16 * k, 2); end
      begin for (int k = 0; k < 3; k++) send(1, 2, 8'hA0 + 16 * k, 2); end
    join
    drain("rr", 400);
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

    // r0 5-byte frame, DONE on the third poll; check the timing chain.
    flag_q = '{32'h0, 32'h0, 32'h20};
    rd_cyc.delete();
    cwq.push_back({4'd9, 4'hF, START});
    evq.push_back(4'b0001);
    send(0, 5, 8'h11, 5);
    drain("f5", 400);
    chk("f5_reads", rd_cyc.size(), 3);
    chk("f5_start_lat", t_start - t_hs, 2);
    if (rd_cyc.size() == 3) begin
      chk("f5_rd0_lat", rd_cyc[0] - t_hs, 3 + PG);
      chk("f5_rd_gap1", rd_cyc[1] - rd_cyc[0], PG + 2);
      chk("f5_rd_gap2", rd_cyc[2] - rd_cyc[1], PG + 2);
      chk("f5_done_lat", t_ev - rd_cyc[2], 3);
    end

    // r1 260-byte frame overflows: 256 writes, no START, one error.
    wr0 = n_wr; cw0 = n_csrw;
    evq.push_back(4'b1000);
    send(1, 260, 0, 260);
    drain("ovf", 400);
    chk("ovf_writes", n_wr - wr0, 256);
    chk("ovf_nostart", n_csrw - cw0, 0);
    cwq.push_back({4'd9, 4'hF, START});
    evq.push_back(4'b0100);
    send(1, 2, 8'h55, 2);
    drain("after_ovf", 400);

    // DONE and ERR in the same sample: error wins.
    flag_q = '{32'hA0};
    cwq.push_back({4'd9, 4'hF, START});
    evq.push_back(4'b0010);
    send(0, 3, 8'h61, 3);
    drain("errdone", 400);

    // Reset in the middle of a 20-byte frame.
    wr0 = n_wr; cw0 = n_csrw; rd0 = n_rd;
    send(0, 20, 8'h80, 10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rn", {r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err}, 0);
    chk("mid_rst_tx", {tx_mm_address, tx_mm_byteenable, tx_mm_write, tx_mm_writedata}, 0);
    chk("mid_rst_csr", {csr_address, csr_byteenable, csr_read, csr_write, csr_writedata}, 0);
    wq.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_rst_wr", n_wr - wr0, 9);
    chk("mid_rst_nostart", n_csrw - cw0, 0);
    chk("mid_rst_noread", n_rd - rd0, 0);

`ifdef CD_TX_SCHED_TIMEOUT_EN
    // Flags never report: watchdog aborts and reports an error.
    flag_dflt = 32'h0;
    cwq.push_back({4'd9, 4'hF, START});
    cwq.push_back({4'd9, 4'hF, 32'h0});
    evq.push_back(4'b0010);
    send(0, 2, 8'h33, 2);
    drain("timeout", 600);
    chk("timeout_lat", {127'd0, (t_ev - t_start) <= (100 + PG + 4)}, 1);
`endif

    chk("end_queues", wq.size() + cwq.size() + evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
